// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell (two half_adders + OR) with a
// registered carry, LSB first, WIDTH shift cycles under a start/done handshake.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, s_r, s_nx;
  logic             c_r, c_nx;
  logic [CW-1:0]    cnt;
  logic             p0, g0, bit_s, g1, last;

  // Full-adder cell: propagate/generate from the operand bits, then fold in carry.
  half_adder u_ha0 (.a(a_r[0]), .b(b_r[0]), .s(p0),    .c(g0));
  half_adder u_ha1 (.a(p0),     .b(c_r),    .s(bit_s), .c(g1));

  assign c_nx = g0 | g1;
  assign s_nx = {bit_s, s_r[WIDTH-1:1]};
  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      c_r   <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      // Flags follow the next state so they line up with the state register.
      busy  <= (state_nx == SHIFT);
      done  <= (state_nx == DONE);
      case (state)
        IDLE: if (start) begin
          a_r <= in1;
          b_r <= in2;
          c_r <= cin;
          cnt <= '0;
          s_r <= '0;
        end
        SHIFT: begin
          a_r <= {1'b0, a_r[WIDTH-1:1]};
          b_r <= {1'b0, b_r[WIDTH-1:1]};
          s_r <= s_nx;
          c_r <= c_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            sum   <= s_nx;
            carry <= c_nx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=13; expected results
// are plain in1+in2+cin sums queued at issue and popped on each done pulse.

module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, cin8 = 1'b0, busy8, done8, carry8;
  logic [7:0]  in1_8 = '0, in2_8 = '0, sum8;
  logic        start13 = 1'b0, cin13 = 1'b0, busy13, done13, carry13;
  logic [12:0] in1_13 = '0, in2_13 = '0, sum13;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in1(in1_8), .in2(in2_8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );
  serial_adder #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .in1(in1_13), .in2(in2_13),
    .cin(cin13), .busy(busy13), .done(done13), .sum(sum13), .carry(carry13)
  );

  int checks = 0, errors = 0;
  logic [8:0]  q8[$];
  logic [13:0] q13[$];
  logic [8:0]  held8 = '0;
  logic [13:0] held13 = '0;
  logic        dq8 = 1'b0, dq13 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Monitors: every done pops one expected result; otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      held8 = '0;
      chk("rst_out8", {done8, busy8, carry8, sum8}, 0);
    end else if (done8) begin
      chk("done_single8", dq8, 0);
      chk("done_expected8", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        held8 = q8.pop_front();
        chk("result8", {carry8, sum8}, held8);
      end
    end else
      chk("hold8", {carry8, sum8}, held8);
    dq8 = done8;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held13 = '0;
      chk("rst_out13", {done13, busy13, carry13, sum13}, 0);
    end else if (done13) begin
      chk("done_single13", dq13, 0);
      chk("done_expected13", q13.size() > 0, 1);
      if (q13.size() > 0) begin
        held13 = q13.pop_front();
        chk("result13", {carry13, sum13}, held13);
      end
    end else
      chk("hold13", {carry13, sum13}, held13);
    dq13 = done13;
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n, bz;
    @(posedge clk); #1;
    in1_8 = a; in2_8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    @(posedge clk); #1;
    start8 = 1'b0; in1_8 = 8'($urandom); in2_8 = 8'($urandom); cin8 = 1'($urandom);
    n = 0; bz = int'(busy8);
    while (!done8 && n < 40) begin
      @(posedge clk); #1; n++;
      if (busy8) bz++;
    end
    chk("latency8", n, 8);
    chk("busy_cycles8", bz, 8);
  endtask

  task automatic op13(input logic [12:0] a, input logic [12:0] b, input logic c);
    int n, bz;
    @(posedge clk); #1;
    in1_13 = a; in2_13 = b; cin13 = c; start13 = 1'b1;
    q13.push_back(14'(a) + 14'(b) + 14'(c));
    @(posedge clk); #1;
    start13 = 1'b0; in1_13 = 13'($urandom); in2_13 = 13'($urandom); cin13 = 1'($urandom);
    n = 0; bz = int'(busy13);
    while (!done13 && n < 60) begin
      @(posedge clk); #1; n++;
      if (busy13) bz++;
    end
    chk("latency13", n, 13);
    chk("busy_cycles13", bz, 13);
  endtask

  initial begin
    int n, t, tlast;
    #2 rst_n = 1'b0;
    #1;
    chk("reset8", {done8, busy8, carry8, sum8}, 0);
    chk("reset13", {done13, busy13, carry13, sum13}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    op8(8'h5A, 8'h3C, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);

    // Start pulse during SHIFT must be dropped.
    @(posedge clk); #1;
    in1_8 = 8'h10; in2_8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h011);
    @(posedge clk); #1 start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in1_8 = 8'hAA; in2_8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("drop_done8", done8, 1);
    repeat (15) @(posedge clk);
    #1 chk("drop_idle8", busy8, 0);

    // Reset mid-operation aborts with no done and clears the outputs.
    @(posedge clk); #1;
    in1_8 = 8'h80; in2_8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h100);
    @(posedge clk); #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort8", {done8, busy8, carry8, sum8}, 0);
    q8.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    op8(8'h80, 8'h80, 1'b0);

    // Back-to-back with start held high.
    @(posedge clk); #1;
    in1_8 = 8'h12; in2_8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h046);
    t = 0; tlast = 0;
    for (int k = 0; k < 3; k++) begin
      do begin @(posedge clk); #1; t++; end while (!done8 && t < 200);
      chk("b2b_done8", done8, 1);
      if (k > 0) chk("b2b_period8", t - tlast, 10);
      tlast = t;
      if (k == 0) begin
        in1_8 = 8'hF0; in2_8 = 8'h0F; cin8 = 1'b1; q8.push_back(9'h100);
      end else if (k == 1) begin
        in1_8 = 8'h7E; in2_8 = 8'h81; cin8 = 1'b0; q8.push_back(9'h0FF);
      end else
        start8 = 1'b0;
    end

    repeat (1000) op8(8'($urandom), 8'($urandom), 1'($urandom));
    repeat (1000) op13(13'($urandom), 13'($urandom), 1'($urandom));

    repeat (5) @(posedge clk);
    #1;
    chk("drain8", q8.size(), 0);
    chk("drain13", q13.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
